countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 144 ++++++++++++++
 tb/tb_countdown_timer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Millisecond countdown timer (hs:min:sec.ms) with load/start/pause control.
// Counts down once per CLKS_PER_MS clock cycles, then expires with a one-cycle done pulse.
module countdown_timer #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [9:0] load_ms,
  input  logic [5:0] load_sec,
  input  logic [5:0] load_min,
  input  logic [4:0] load_hs,
  input  logic       start,
  input  logic       pause,
  output logic [9:0] ms,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hs,
  output logic       running,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  localparam int              PW        = $clog2(CLKS_PER_MS);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLKS_PER_MS - 1);

  state_t        state;
  logic [PW-1:0] presc;

  logic [9:0] clamp_ms;
  logic [5:0] clamp_sec, clamp_min;
  logic [4:0] clamp_hs;
  logic [9:0] dec_ms;
  logic [5:0] dec_sec, dec_min;
  logic [4:0] dec_hs;
  logic       tick, final_tick, count_nonzero, load_ok;

  always_comb begin
    clamp_ms  = (load_ms  > 10'd999) ? 10'd999 : load_ms;
    clamp_sec = (load_sec > 6'd59)   ? 6'd59   : load_sec;
    clamp_min = (load_min > 6'd59)   ? 6'd59   : load_min;
    clamp_hs  = (load_hs  > 5'd23)   ? 5'd23   : load_hs;
  end

  // Borrow chain: ms -> sec -> min -> hs; only reached with a nonzero count.
  always_comb begin
    dec_ms  = ms;
    dec_sec = sec;
    dec_min = min;
    dec_hs  = hs;
    if (ms != 10'd0) begin
      dec_ms = ms - 10'd1;
    end else begin
      dec_ms = 10'd999;
      if (sec != 6'd0) begin
        dec_sec = sec - 6'd1;
      end else begin
        dec_sec = 6'd59;
        if (min != 6'd0) begin
          dec_min = min - 6'd1;
        end else begin
          dec_min = 6'd59;
          dec_hs  = hs - 5'd1;
        end
      end
    end
  end

  assign tick          = (presc == PRESC_MAX);
  assign final_tick    = tick && (ms == 10'd1) && (sec == 6'd0) && (min == 6'd0) && (hs == 5'd0);
  assign count_nonzero = (ms != 10'd0) || (sec != 6'd0) || (min != 6'd0) || (hs != 5'd0);
  assign load_ok       = load && (state != RUN);

  // NOTE: asynchronous reset in the sensitivity list so outputs clear without a clock;
  // all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      ms      <= '0;
      sec     <= '0;
      min     <= '0;
      hs      <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load_ok) begin
        ms      <= clamp_ms;
        sec     <= clamp_sec;
        min     <= clamp_min;
        hs      <= clamp_hs;
        presc   <= '0;
        state   <= IDLE;
        running <= 1'b0;
        expired <= 1'b0;
      end else begin
        case (state)
          IDLE, PAUSED: begin
            if (start && count_nonzero) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end
          RUN: begin
            // The final tick outranks a coincident pause.
            if (final_tick) begin
              ms      <= '0;
              sec     <= '0;
              min     <= '0;
              hs      <= '0;
              presc   <= '0;
              state   <= EXPIRED;
              running <= 1'b0;
              expired <= 1'b1;
              done    <= 1'b1;
            end else if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (tick) begin
              ms    <= dec_ms;
              sec   <= dec_sec;
              min   <= dec_min;
              hs    <= dec_hs;
              presc <= '0;
            end else begin
              presc <= presc + PW'(1);
            end
          end
          EXPIRED: begin
            running <= 1'b0;
            expired <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with CLKS_PER_MS = 4: table-driven
// load/start vectors plus hand-written multi-cycle countdown sequences.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [9:0] load_ms = '0;
  logic [5:0] load_sec = '0;
  logic [5:0] load_min = '0;
  logic [4:0] load_hs = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] ms;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hs;
  logic       running, done, expired;

  int n_pass = 0;
  int n_total = 0;

  countdown_timer #(.CLKS_PER_MS(4)) dut (
    .clk(clk), .rst(rst), .load(load),
    .load_ms(load_ms), .load_sec(load_sec), .load_min(load_min), .load_hs(load_hs),
    .start(start), .pause(pause),
    .ms(ms), .sec(sec), .min(min), .hs(hs),
    .running(running), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [9:0] lms;
    logic [5:0] lsec;
    logic [5:0] lmin;
    logic [4:0] lhs;
    logic       st;
    logic       pa;
    logic [9:0] ems;
    logic [5:0] esec;
    logic [5:0] emin;
    logic [4:0] ehs;
    logic       erun;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [9:0] lms, input logic [5:0] lsec,
                       input logic [5:0] lmin, input logic [4:0] lhs,
                       input logic st, input logic pa);
    load = ld; load_ms = lms; load_sec = lsec; load_min = lmin; load_hs = lhs;
    start = st; pause = pa;
  endtask

  task automatic clear_in();
    drive(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic cycle(input logic ld, input logic [9:0] lms, input logic [5:0] lsec,
                       input logic [5:0] lmin, input logic [4:0] lhs,
                       input logic st, input logic pa);
    drive(ld, lms, lsec, lmin, lhs, st, pa);
    step();
    clear_in();
  endtask

  task automatic check_time(input string tag, input int ems, input int esec,
                            input int emin, input int ehs);
    check({tag, ".ms"},  32'(ms),  32'(ems));
    check({tag, ".sec"}, 32'(sec), 32'(esec));
    check({tag, ".min"}, 32'(min), 32'(emin));
    check({tag, ".hs"},  32'(hs),  32'(ehs));
  endtask

  initial begin
    int exp_ms;
    int dcount;

    //            ld   lms      lsec    lmin    lhs    st   pa    ems      esec    emin    ehs    erun
    vecs[0] = '{1'b0, 10'd0,    6'd0,   6'd0,   5'd0,  1'b1, 1'b0, 10'd0,   6'd0,   6'd0,   5'd0,  1'b0};
    vecs[1] = '{1'b1, 10'd1023, 6'd63,  6'd63,  5'd31, 1'b0, 1'b0, 10'd999, 6'd59,  6'd59,  5'd23, 1'b0};
    vecs[2] = '{1'b1, 10'd5,    6'd2,   6'd3,   5'd4,  1'b0, 1'b0, 10'd5,   6'd2,   6'd3,   5'd4,  1'b0};
    vecs[3] = '{1'b1, 10'd0,    6'd0,   6'd0,   5'd0,  1'b0, 1'b0, 10'd0,   6'd0,   6'd0,   5'd0,  1'b0};
    vecs[4] = '{1'b0, 10'd0,    6'd0,   6'd0,   5'd0,  1'b1, 1'b0, 10'd0,   6'd0,   6'd0,   5'd0,  1'b0};
    vecs[5] = '{1'b1, 10'd7,    6'd1,   6'd2,   5'd3,  1'b1, 1'b1, 10'd7,   6'd1,   6'd2,   5'd3,  1'b0};
    vecs[6] = '{1'b0, 10'd0,    6'd0,   6'd0,   5'd0,  1'b0, 1'b0, 10'd7,   6'd1,   6'd2,   5'd3,  1'b0};
    vecs[7] = '{1'b1, 10'd1000, 6'd60,  6'd60,  5'd24, 1'b0, 1'b0, 10'd999, 6'd59,  6'd59,  5'd23, 1'b0};
    vecs[8] = '{1'b1, 10'd999,  6'd59,  6'd59,  5'd23, 1'b0, 1'b0, 10'd999, 6'd59,  6'd59,  5'd23, 1'b0};

    // Reset state, observed between clock edges while rst is high.
    #12;
    check_time("reset", 0, 0, 0, 0);
    check("reset.running", 32'(running), 0);
    check("reset.done",    32'(done),    0);
    check("reset.expired", 32'(expired), 0);
    #1 rst = 1'b0;
    step();

    // Table: clamping, zero-count start, load > start > pause priority in IDLE.
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].ld, vecs[i].lms, vecs[i].lsec, vecs[i].lmin, vecs[i].lhs, vecs[i].st, vecs[i].pa);
      check_time($sformatf("vec%0d", i), 32'(vecs[i].ems), 32'(vecs[i].esec),
                 32'(vecs[i].emin), 32'(vecs[i].ehs));
      check($sformatf("vec%0d.running", i), 32'(running), 32'(vecs[i].erun));
      check($sformatf("vec%0d.expired", i), 32'(expired), 0);
    end

    // Countdown 0:00:00.003 to expiry; done exactly one cycle, aligned with zero.
    cycle(1'b1, 10'd3, 6'd0, 6'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0);
    check("cd3.start_running", 32'(running), 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_ms = (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0;
      check($sformatf("cd3.ms@%0d", k), 32'(ms), 32'(exp_ms));
      check($sformatf("cd3.done@%0d", k), 32'(done), (k == 12) ? 1 : 0);
      check($sformatf("cd3.running@%0d", k), 32'(running), (k < 12) ? 1 : 0);
      check($sformatf("cd3.expired@%0d", k), 32'(expired), (k >= 12) ? 1 : 0);
    end
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0);
    step();
    check("exp.start_ignored_run", 32'(running), 0);
    check("exp.start_ignored_exp", 32'(expired), 1);
    check("exp.no_second_done", 32'(done), 0);

    // Borrow from seconds.
    cycle(1'b1, 10'd0, 6'd1, 6'd0, 5'd0, 1'b0, 1'b0);
    check("borrow1.expired_cleared", 32'(expired), 0);
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step();
    check_time("borrow1", 999, 0, 0, 0);
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1);
    check("borrow1.paused", 32'(running), 0);

    // Borrow through the full chain, then a load during RUN must be ignored.
    cycle(1'b1, 10'd0, 6'd0, 6'd0, 5'd1, 1'b0, 1'b0);
    check_time("load_hs", 0, 0, 0, 1);
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step();
    check_time("borrow_hs", 999, 59, 59, 0);
    cycle(1'b1, 10'd5, 6'd5, 6'd5, 5'd5, 1'b0, 1'b0);
    check_time("run_load_ignored", 999, 59, 59, 0);
    check("run_load_ignored.running", 32'(running), 1);
    for (int k = 0; k < 3; k++) step();
    check("run_continues.ms", 32'(ms), 998);

    // Pause after two ticks, hold, resume with prescaler zeroed.
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1);
    cycle(1'b1, 10'd10, 6'd0, 6'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step();
    check("pause.ms_before", 32'(ms), 8);
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1);
    check("pause.running", 32'(running), 0);
    for (int k = 0; k < 20; k++) step();
    check("pause.ms_held", 32'(ms), 8);
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0);
    check("resume.running", 32'(running), 1);
    for (int k = 0; k < 3; k++) step();
    check("resume.ms_at3", 32'(ms), 8);
    step();
    check("resume.ms_at4", 32'(ms), 7);

    // Pause coinciding with the final tick: expiry wins.
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1);
    cycle(1'b1, 10'd1, 6'd0, 6'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step();
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1);
    check("pause_final.done", 32'(done), 1);
    check("pause_final.expired", 32'(expired), 1);
    check("pause_final.running", 32'(running), 0);
    check("pause_final.ms", 32'(ms), 0);

    // Asynchronous reset mid-RUN, then no done and start refused on zero count.
    cycle(1'b1, 10'd2, 6'd0, 6'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0);
    step();
    step();
    #3 rst = 1'b1;
    #1;
    check_time("async_rst", 0, 0, 0, 0);
    check("async_rst.running", 32'(running), 0);
    check("async_rst.expired", 32'(expired), 0);
    #2 rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done) dcount++;
    end
    check("post_rst.no_done", 32'(dcount), 0);
    check("post_rst.expired", 32'(expired), 0);
    cycle(1'b0, 10'd0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0);
    check("post_rst.start_refused", 32'(running), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
